multicycle_acc_core: RTL and testbench
======================================

// Module: multicycle_acc_core
// PURPOSE
//  Parametrised multi-cycle accumulator processor core; successor to the single-cycle 9-bit top level.
//  Fetches 9-bit instructions over a valid-handshake instruction port.
//  Executes them against an accumulator (ACC), an NREG-entry register file, and carry (C) and zero (Z) flags.
//  Accesses data memory over a req/ack port, so ROMs and memories with wait states are supported.
//  Sits between instruction ROM and data memory; the testbench sees halt and the performance counters.
// PARAMETERS
//  W     8   datapath width: ACC, registers, data memory address and data
//  NREG  16  register file depth; legal range 2..16; operand field r indexes modulo NREG
//  PCW   10  program counter width
//  CTW   16  width of cycle_ct and instr_ct
// PORTS
//  CLK         in   1     clock, posedge
//  start_n     in   1     asynchronous active-low reset
//  inst_addr   out  PCW   instruction address (= PC)
//  inst_req    out  1     high in FETCH state
//  inst_data   in   9     instruction word, sampled when inst_req & inst_valid
//  inst_valid  in   1     inst_data valid
//  dmem_addr   out  W     data address (= R[r]); held stable while dmem_req
//  dmem_wdata  out  W     store data (= ACC)
//  dmem_we     out  1     1 = store, 0 = load; qualified by dmem_req
//  dmem_req    out  1     memory request; held until dmem_ack
//  dmem_rdata  in   W     load data, sampled when dmem_req & dmem_ack
//  dmem_ack    in   1     request complete; may be asserted in the same cycle as req
//  halt        out  1     sticky done flag
//  cycle_ct    out  CTW   clocks since reset while !halt
//  instr_ct    out  CTW   instructions retired
// BEHAVIOUR
//  Reset (async, start_n=0):
//   - PC=0, ACC=0, C=0, Z=0, all registers 0, IR=0, counters 0.
//   - state=FETCH; halt=0; inst_req and dmem_req deassert immediately.
//   - Reset mid-transaction aborts the transaction; no register or flag write occurs.
//  ISA, instruction field I[8:0]:
//   - I[8]=1: SET: ACC <= zext(I[7:0]) truncated to W; updates Z.
//   - I[8]=0: op=I[7:4], r=I[3:0]:
//     0 HALT.
//     1 STR: R[r] <= ACC.
//     2 LDR: ACC <= R[r].
//     3 ADD: {C,ACC} <= ACC + R[r] + C.
//     4 LDM: ACC <= MEM[R[r]].
//     5 STM: MEM[R[r]] <= ACC.
//     6 SUB: ACC <= ACC - R[r]; C <= borrow.
//     7 AND.
//     8 XOR.
//     9 SHL: {C,ACC} <= {ACC,C}.
//     A SHR: {ACC,C} <= {C,ACC}.
//     B CLC: C <= 0.
//     C BZ:  if Z, PC <= PC + sext(r), range -8..+7.
//     D BNZ: if !Z, same as BZ.
//     E JMP: PC <= R[r], zero-extended or truncated to PCW.
//     F CMP: Z <= (ACC == R[r]); C <= (ACC < R[r]) unsigned; ACC unchanged.
//   - Z <= (new ACC == 0) for SET, LDR, ADD, LDM, SUB, AND, XOR, SHL, SHR.
//   - All other ops leave flags unchanged.
//   - All arithmetic is modulo 2^W; PC arithmetic is modulo 2^PCW, so 2^PCW-1 + 1 wraps to 0.
//  FSM:
//   - FETCH: inst_req=1. On inst_valid, IR <= inst_data and go to EXEC; otherwise stay.
//   - EXEC, one cycle:
//     * HALT -> HALTED.
//     * LDM/STM -> MEM.
//     * All other ops: commit, PC <= next PC (PC+1 or branch target), instr_ct++, go to FETCH.
//   - MEM: dmem_req=1 with addr/we/wdata stable.
//     * On dmem_ack: LDM writes ACC and Z; PC+1; instr_ct++; go to FETCH.
//   - HALTED: halt=1, no requests, all state frozen; only reset exits.
//     * HALT retires: instr_ct counts it.
//  Latency:
//   - ALU/branch op: 2 clocks with zero-wait inst_valid.
//   - LDM/STM: 3 clocks with same-cycle ack.
//   - Each wait cycle adds 1.
//  Edge cases:
//   - inst_valid or dmem_ack outside FETCH/MEM is ignored.
//   - Taken branch with offset 0 is a self-loop.
//   - cycle_ct and instr_ct wrap at 2^CTW.
//   - cycle_ct stops in the cycle halt rises.
// TESTING
//  T1: SET 5; STR r1; SET 3; ADD r1; HALT, zero-wait
//      -> ACC=8, Z=0, C=0, instr_ct=5, halt=1, cycle_ct=10.
//  T2: SET 0xFF; STR r2; SET 1; ADD r2
//      -> ACC=0, C=1, Z=1; then SHL -> ACC=1, C=0.
//  T3: STM with dmem_ack delayed 3 cycles
//      -> dmem_req high 4 cycles, addr/wdata stable throughout, single write.
//      Then LDM same address -> ACC equals stored value.
//  T4: Z=1, BZ at PC=2 with r=4'hE -> next fetch at PC=0.
//      BNZ under Z=1 -> PC=3.
//      PC=2^PCW-1 non-branch -> PC wraps to 0.
//  T5: inst_valid withheld 5 cycles -> IR and PC unchanged, cycle_ct +5, instr_ct unchanged.
//  T6: start_n low during MEM wait -> dmem_req drops asynchronously, ACC/PC/counters=0.
//      After release, fetch resumes from PC 0.

Source files
------------

// File: rtl/multicycle_acc_core.sv
// Multi-cycle accumulator core: FETCH/EXEC/MEM/HALTED control, ACC, register
// file, C/Z flags, valid-handshake instruction port, req/ack data port.
// Ports: CLK, start_n (async low reset); inst_addr/inst_req/inst_data/inst_valid
// instruction fetch; dmem_addr/dmem_wdata/dmem_we/dmem_req/dmem_rdata/dmem_ack
// data memory; halt (sticky), cycle_ct (clocks while running), instr_ct (retired).
module multicycle_acc_core #(
    parameter int W    = 8,
    parameter int NREG = 16,
    parameter int PCW  = 10,
    parameter int CTW  = 16
) (
    input  logic           CLK,
    input  logic           start_n,
    output logic [PCW-1:0] inst_addr,
    output logic           inst_req,
    input  logic [8:0]     inst_data,
    input  logic           inst_valid,
    output logic [W-1:0]   dmem_addr,
    output logic [W-1:0]   dmem_wdata,
    output logic           dmem_we,
    output logic           dmem_req,
    input  logic [W-1:0]   dmem_rdata,
    input  logic           dmem_ack,
    output logic           halt,
    output logic [CTW-1:0] cycle_ct,
    output logic [CTW-1:0] instr_ct
);

    localparam int RIW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_STR  = 4'h1;
    localparam logic [3:0] OP_LDR  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_LDM  = 4'h4;
    localparam logic [3:0] OP_STM  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_CLC  = 4'hB;
    localparam logic [3:0] OP_BZ   = 4'hC;
    localparam logic [3:0] OP_BNZ  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_CMP  = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d, pc_inc, br_off;
    logic [8:0]     ir_q, ir_d;
    logic [W-1:0]   acc, acc_d, rval;
    logic           c_flag, c_d, z_flag, z_d;
    logic [W-1:0]   regs [NREG];
    logic [CTW-1:0] cyc_q, ins_q;
    logic [3:0]     op, rsel;
    logic [RIW-1:0] ridx;
    logic [W:0]     add_sum;
    logic           reg_we, retire, acc_wr;

    assign op      = ir_q[7:4];
    assign rsel    = ir_q[3:0];
    // Operand field wraps onto the register file when NREG < 16.
    assign ridx    = RIW'(32'(rsel) % NREG);
    assign rval    = regs[ridx];
    assign pc_inc  = pc_q + PCW'(1);
    assign br_off  = {{(PCW-4){rsel[3]}}, rsel};
    assign add_sum = {1'b0, acc} + {1'b0, rval} + {{W{1'b0}}, c_flag};

    // Requests are gated by start_n so they fall the moment reset asserts.
    assign inst_addr  = pc_q;
    assign inst_req   = start_n & (state_q == S_FETCH);
    assign dmem_req   = start_n & (state_q == S_MEM);
    assign dmem_addr  = rval;
    assign dmem_wdata = acc;
    assign dmem_we    = (op == OP_STM);
    assign halt       = (state_q == S_HALTED);
    assign cycle_ct   = cyc_q;
    assign instr_ct   = ins_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc;
        c_d     = c_flag;
        z_d     = z_flag;
        reg_we  = 1'b0;
        retire  = 1'b0;
        acc_wr  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (inst_valid) begin
                    ir_d    = inst_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                retire  = 1'b1;
                unique case (1'b1)
                    ir_q[8]: begin
                        acc_d  = W'(ir_q[7:0]);
                        acc_wr = 1'b1;
                    end
                    !ir_q[8]: begin
                        unique case (op)
                            OP_HALT: begin
                                state_d = S_HALTED;
                                pc_d    = pc_q;
                            end
                            OP_STR: reg_we = 1'b1;
                            OP_LDR: begin
                                acc_d  = rval;
                                acc_wr = 1'b1;
                            end
                            OP_ADD: begin
                                {c_d, acc_d} = add_sum;
                                acc_wr       = 1'b1;
                            end
                            OP_LDM, OP_STM: begin
                                // Retires only once the memory acks.
                                state_d = S_MEM;
                                pc_d    = pc_q;
                                retire  = 1'b0;
                            end
                            OP_SUB: begin
                                acc_d  = acc - rval;
                                c_d    = (acc < rval);
                                acc_wr = 1'b1;
                            end
                            OP_AND: begin
                                acc_d  = acc & rval;
                                acc_wr = 1'b1;
                            end
                            OP_XOR: begin
                                acc_d  = acc ^ rval;
                                acc_wr = 1'b1;
                            end
                            OP_SHL: begin
                                {c_d, acc_d} = {acc, c_flag};
                                acc_wr       = 1'b1;
                            end
                            OP_SHR: begin
                                {acc_d, c_d} = {c_flag, acc};
                                acc_wr       = 1'b1;
                            end
                            OP_CLC: c_d = 1'b0;
                            OP_BZ: begin
                                if (z_flag) pc_d = pc_q + br_off;
                            end
                            OP_BNZ: begin
                                if (!z_flag) pc_d = pc_q + br_off;
                            end
                            OP_JMP: pc_d = PCW'(rval);
                            OP_CMP: begin
                                z_d = (acc == rval);
                                c_d = (acc < rval);
                            end
                        endcase
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (!dmem_we) begin
                        acc_d  = dmem_rdata;
                        acc_wr = 1'b1;
                    end
                    pc_d    = pc_inc;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
            end
        endcase
        if (acc_wr) z_d = (acc_d == '0);
    end

    always_ff @(posedge CLK or negedge start_n) begin
        if (!start_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            acc     <= '0;
            c_flag  <= 1'b0;
            z_flag  <= 1'b0;
            cyc_q   <= '0;
            ins_q   <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc     <= acc_d;
            c_flag  <= c_d;
            z_flag  <= z_d;
            if (reg_we) regs[ridx] <= acc;
            if (state_q != S_HALTED) cyc_q <= cyc_q + CTW'(1);
            if (retire) ins_q <= ins_q + CTW'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_acc_core.sv
// Bench for multicycle_acc_core: vector table, hand sequences for
// handshake corners, and random programs against an ISA-level model.
module tb_multicycle_acc_core;

    logic       CLK = 1'b0;
    logic       start_n;
    logic [9:0] inst_addr;
    logic       inst_req;
    logic [8:0] inst_data = '0;
    logic       inst_valid = 1'b0;
    logic [7:0] dmem_addr, dmem_wdata;
    logic       dmem_we, dmem_req;
    logic [7:0] dmem_rdata = '0;
    logic       dmem_ack = 1'b0;
    logic       halt;
    logic [15:0] cycle_ct, instr_ct;

    always #5 CLK = ~CLK;

    multicycle_acc_core dut (
        .CLK(CLK), .start_n(start_n),
        .inst_addr(inst_addr), .inst_req(inst_req),
        .inst_data(inst_data), .inst_valid(inst_valid),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_we(dmem_we), .dmem_req(dmem_req),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .halt(halt), .cycle_ct(cycle_ct), .instr_ct(instr_ct)
    );

    int total = 0;
    int bad = 0;

    logic [8:0] rom [1024];
    logic [7:0] mem [256];
    int         mm [256];

    bit rand_mode = 0;
    int iwait = 0, dwait = 0;
    int icnt = 0, dcnt = 0, txn_cyc = 0;
    int istall = 0, dstall = 0, wr_count = 0, unstable = 0;
    logic [7:0] cap_addr, cap_wdata;
    int fetch_log[$];
    int txn_log[$];

    // Instruction ROM responder with programmable wait states.
    always @(negedge CLK) begin
        if (inst_req) begin
            if (icnt < iwait) begin
                inst_valid = 1'b0;
                icnt++;
                istall++;
            end else begin
                inst_valid = 1'b1;
                inst_data  = rom[inst_addr];
                fetch_log.push_back(int'(inst_addr));
                if (rand_mode) iwait = $urandom_range(0, 2);
            end
        end else begin
            icnt       = 0;
            inst_valid = rand_mode ? 1'($urandom) : 1'b0;
            inst_data  = 9'($urandom);
        end
    end

    // Data memory responder; also watches request stability.
    always @(negedge CLK) begin
        if (dmem_req) begin
            if (txn_cyc == 0) begin
                cap_addr  = dmem_addr;
                cap_wdata = dmem_wdata;
            end else if (dmem_addr !== cap_addr ||
                         (dmem_we && dmem_wdata !== cap_wdata)) begin
                unstable++;
            end
            txn_cyc++;
            if (dcnt < dwait) begin
                dmem_ack = 1'b0;
                dcnt++;
                dstall++;
            end else begin
                dmem_ack   = 1'b1;
                dmem_rdata = mem[dmem_addr];
                if (dmem_we) begin
                    mem[dmem_addr] = dmem_wdata;
                    wr_count++;
                end
                txn_log.push_back(txn_cyc);
                if (rand_mode) dwait = $urandom_range(0, 2);
            end
        end else begin
            dcnt       = 0;
            txn_cyc    = 0;
            dmem_ack   = rand_mode ? 1'($urandom) : 1'b0;
            dmem_rdata = 8'($urandom);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = '0;
    endtask

    task automatic do_reset();
        start_n = 1'b0;
        #1;
        istall = 0;
        dstall = 0;
        wr_count = 0;
        unstable = 0;
        fetch_log.delete();
        txn_log.delete();
        repeat (2) @(posedge CLK);
        #1 start_n = 1'b1;
    endtask

    task automatic wait_halt(input int budget, input string nm);
        int n = 0;
        while (!halt && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk(nm, 32'(halt), 32'd1);
    endtask

    function automatic int log_at(input int i);
        return (fetch_log.size() > i) ? fetch_log[i] : -1;
    endfunction

    // ISA-level reference: runs the ROM program sequentially on ints.
    task automatic model_run(output int m_acc, output int m_c,
                             output int m_z, output int n_ins,
                             output int n_mem);
        int acc = 0, c = 0, z = 0, pc = 0, nxt, ins, op, ri, rv, s, off;
        int r [16];
        for (int i = 0; i < 16; i++) r[i] = 0;
        n_ins = 0;
        n_mem = 0;
        for (int step = 0; step < 5000; step++) begin
            ins = int'(rom[pc]);
            n_ins++;
            nxt = (pc + 1) % 1024;
            op = (ins >> 4) & 15;
            ri = ins & 15;
            rv = r[ri];
            off = (ri >= 8) ? ri - 16 : ri;
            if (ins >= 256) begin
                acc = ins & 255;
                z = (acc == 0);
            end else begin
                if (op == 0) break;
                case (op)
                    1: r[ri] = acc;
                    2: begin acc = rv; z = (acc == 0); end
                    3: begin
                        s = acc + rv + c;
                        acc = s % 256; c = s / 256; z = (acc == 0);
                    end
                    4: begin acc = mm[rv]; n_mem++; z = (acc == 0); end
                    5: begin mm[rv] = acc; n_mem++; end
                    6: begin
                        c = (acc < rv);
                        acc = (acc - rv + 256) % 256; z = (acc == 0);
                    end
                    7: begin acc = acc & rv; z = (acc == 0); end
                    8: begin acc = acc ^ rv; z = (acc == 0); end
                    9: begin
                        s = acc * 2 + c;
                        c = s / 256; acc = s % 256; z = (acc == 0);
                    end
                    10: begin
                        s = c * 256 + acc;
                        c = s % 2; acc = s / 2; z = (acc == 0);
                    end
                    11: c = 0;
                    12: if (z != 0) nxt = (pc + off + 1024) % 1024;
                    13: if (z == 0) nxt = (pc + off + 1024) % 1024;
                    14: nxt = rv % 1024;
                    15: begin z = (acc == rv); c = (acc < rv); end
                    default: ;
                endcase
            end
            pc = nxt;
        end
        m_acc = acc;
        m_c = c;
        m_z = z;
    endtask

    typedef struct packed {
        logic [7:0][8:0] prog;
        logic [7:0]      acc;
        logic            c;
        logic            z;
        logic [15:0]     ic;
        logic [15:0]     cc;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(
        input logic [8:0] p0, p1, p2, p3, p4, p5, p6, p7,
        input logic [7:0] acc, input logic c, input logic z,
        input int ic, input int cc);
        vec_t v;
        v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2; v.prog[3] = p3;
        v.prog[4] = p4; v.prog[5] = p5; v.prog[6] = p6; v.prog[7] = p7;
        v.acc = acc; v.c = c; v.z = z;
        v.ic = 16'(ic); v.cc = 16'(cc);
        vecs.push_back(v);
    endtask

    initial begin
        int m_acc, m_c, m_z, n_ins, n_mem, nmis, k, opr, ri, len;
        string nm;

        // prog slots ... expected acc, C, Z, instr_ct, cycle_ct
        add_vec(9'h105, 9'h011, 9'h103, 9'h031, 9'h000, 0, 0, 0,
                8'h08, 0, 0, 5, 10);
        add_vec(9'h1FF, 9'h012, 9'h101, 9'h032, 9'h090, 9'h000, 0, 0,
                8'h01, 0, 0, 6, 12);
        add_vec(9'h103, 9'h014, 9'h101, 9'h064, 9'h0A0, 9'h000, 0, 0,
                8'hFF, 0, 0, 6, 12);
        add_vec(9'h142, 9'h013, 9'h0F3, 9'h110, 9'h0F3, 9'h000, 0, 0,
                8'h10, 1, 0, 6, 12);
        add_vec(9'h100, 9'h0C2, 9'h177, 9'h109, 9'h000, 0, 0, 0,
                8'h09, 0, 0, 4, 8);
        add_vec(9'h100, 9'h0D2, 9'h177, 9'h000, 0, 0, 0, 0,
                8'h77, 0, 0, 4, 8);
        add_vec(9'h1F0, 9'h015, 9'h13C, 9'h075, 9'h085, 9'h000, 0, 0,
                8'hC0, 0, 0, 6, 12);
        add_vec(9'h180, 9'h016, 9'h036, 9'h0B0, 9'h036, 9'h000, 0, 0,
                8'h80, 0, 0, 6, 12);
        add_vec(9'h104, 9'h017, 9'h0E7, 9'h155, 9'h000, 0, 0, 0,
                8'h04, 0, 0, 4, 8);
        add_vec(9'h120, 9'h018, 9'h199, 9'h058, 9'h100, 9'h048, 9'h000, 0,
                8'h99, 0, 0, 7, 16);
        add_vec(9'h100, 9'h019, 9'h105, 9'h029, 9'h000, 0, 0, 0,
                8'h00, 0, 1, 5, 10);
        add_vec(9'h181, 9'h090, 9'h090, 9'h000, 0, 0, 0, 0,
                8'h05, 0, 0, 4, 8);

        start_n = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        clear_rom();
        #3 start_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_inst_req", 32'(inst_req), 0);
        chk("rst_dmem_req", 32'(dmem_req), 0);
        chk("rst_halt", 32'(halt), 0);
        chk("rst_pc", 32'(inst_addr), 0);
        chk("rst_cyc", 32'(cycle_ct), 0);
        chk("rst_ins", 32'(instr_ct), 0);

        foreach (vecs[v]) begin
            clear_rom();
            for (int i = 0; i < 8; i++) rom[i] = vecs[v].prog[i];
            iwait = 0;
            dwait = 0;
            do_reset();
            wait_halt(200, $sformatf("v%0d_halt", v));
            chk($sformatf("v%0d_acc", v), 32'(dut.acc), 32'(vecs[v].acc));
            chk($sformatf("v%0d_c", v), 32'(dut.c_flag), 32'(vecs[v].c));
            chk($sformatf("v%0d_z", v), 32'(dut.z_flag), 32'(vecs[v].z));
            chk($sformatf("v%0d_ic", v), 32'(instr_ct), 32'(vecs[v].ic));
            chk($sformatf("v%0d_cc", v), 32'(cycle_ct), 32'(vecs[v].cc));
        end

        // Frozen after halt.
        repeat (4) @(posedge CLK);
        #1;
        chk("halt_frozen_cc", 32'(cycle_ct), 8);
        chk("halt_no_req", 32'(inst_req | dmem_req), 0);

        // Store with 3 wait states, then load back.
        clear_rom();
        rom[0] = 9'h130; rom[1] = 9'h011; rom[2] = 9'h1A5; rom[3] = 9'h051;
        rom[4] = 9'h100; rom[5] = 9'h041; rom[6] = 9'h000;
        iwait = 0;
        dwait = 3;
        do_reset();
        wait_halt(200, "stm_halt");
        chk("stm_req_len", (txn_log.size() > 0) ? txn_log[0] : -1, 4);
        chk("ldm_req_len", (txn_log.size() > 1) ? txn_log[1] : -1, 4);
        chk("stm_stable", unstable, 0);
        chk("stm_writes", wr_count, 1);
        chk("stm_mem", 32'(mem[8'h30]), 32'h A5);
        chk("ldm_acc", 32'(dut.acc), 32'h A5);
        chk("mem_cc", 32'(cycle_ct), 22);
        chk("mem_ic", 32'(instr_ct), 7);

        // Branch back to 0 by offset -2.
        clear_rom();
        rom[0] = 9'h100; rom[1] = 9'h0B0; rom[2] = 9'h0CE;
        dwait = 0;
        do_reset();
        repeat (14) @(posedge CLK);
        #1;
        chk("bz_back_f3", log_at(3), 0);
        chk("bz_back_f6", log_at(6), 0);
        chk("bz_loop_ic", 32'(instr_ct), 7);
        chk("bz_loop_nohalt", 32'(halt), 0);

        // BNZ not taken under Z=1.
        clear_rom();
        rom[0] = 9'h100; rom[1] = 9'h0B0; rom[2] = 9'h0DE;
        do_reset();
        wait_halt(50, "bnz_halt");
        chk("bnz_fall_f3", log_at(3), 3);

        // PC wraps both ways across 2^PCW.
        clear_rom();
        rom[0] = 9'h100; rom[1] = 9'h0CE; rom[1023] = 9'h111;
        do_reset();
        repeat (8) @(posedge CLK);
        #1;
        chk("wrap_f2", log_at(2), 1023);
        chk("wrap_f3", log_at(3), 0);

        // Withheld inst_valid.
        clear_rom();
        rom[0] = 9'h107;
        iwait = 5;
        do_reset();
        repeat (5) @(posedge CLK);
        #1;
        chk("stall_cc", 32'(cycle_ct), 5);
        chk("stall_ic", 32'(instr_ct), 0);
        chk("stall_pc", 32'(inst_addr), 0);
        chk("stall_ir", 32'(dut.ir_q), 0);
        wait_halt(100, "stall_halt");
        chk("stall_tot_cc", 32'(cycle_ct), 14);
        chk("stall_tot_ic", 32'(instr_ct), 2);
        iwait = 0;

        // Reset in the middle of a memory wait.
        clear_rom();
        rom[0] = 9'h140; rom[1] = 9'h011; rom[2] = 9'h112; rom[3] = 9'h051;
        dwait = 10;
        do_reset();
        k = 0;
        while (!dmem_req && k < 30) begin
            @(negedge CLK);
            #1;
            k++;
        end
        chk("abort_req_seen", 32'(dmem_req), 1);
        repeat (2) @(negedge CLK);
        #2 start_n = 1'b0;
        #1;
        chk("abort_dreq", 32'(dmem_req), 0);
        chk("abort_ireq", 32'(inst_req), 0);
        chk("abort_pc", 32'(inst_addr), 0);
        chk("abort_acc", 32'(dut.acc), 0);
        chk("abort_reg", 32'(dut.regs[1]), 0);
        chk("abort_cc", 32'(cycle_ct), 0);
        chk("abort_ic", 32'(instr_ct), 0);
        chk("abort_writes", wr_count, 0);
        fetch_log.delete();
        dwait = 0;
        @(posedge CLK);
        #1 start_n = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("resume_f0", log_at(0), 0);
        chk("resume_acc", 32'(dut.acc), 32'h40);

        // Random programs with random wait states and noise on idle inputs.
        for (int t = 0; t < 25; t++) begin
            clear_rom();
            len = $urandom_range(10, 40);
            for (int i = 0; i < len; i++) begin
                k = $urandom_range(0, 99);
                if (k < 25) begin
                    rom[i] = {1'b1, 8'($urandom)};
                end else begin
                    opr = $urandom_range(1, 15);
                    if (opr == 14) opr = 1;
                    ri = $urandom_range(0, 15);
                    if (opr == 12 || opr == 13) ri = $urandom_range(1, 7);
                    rom[i] = {1'b0, 4'(opr), 4'(ri)};
                end
            end
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom);
                mm[i] = int'(mem[i]);
            end
            model_run(m_acc, m_c, m_z, n_ins, n_mem);
            rand_mode = 1;
            iwait = $urandom_range(0, 2);
            dwait = $urandom_range(0, 2);
            do_reset();
            nm = $sformatf("rnd%0d", t);
            wait_halt(3000, {nm, "_halt"});
            chk({nm, "_acc"}, 32'(dut.acc), m_acc);
            chk({nm, "_c"}, 32'(dut.c_flag), m_c);
            chk({nm, "_z"}, 32'(dut.z_flag), m_z);
            chk({nm, "_ic"}, 32'(instr_ct), n_ins);
            chk({nm, "_cc"}, 32'(cycle_ct),
                2 * n_ins + n_mem + istall + dstall);
            nmis = 0;
            for (int i = 0; i < 256; i++)
                if (int'(mem[i]) != mm[i]) nmis++;
            chk({nm, "_mem"}, nmis, 0);
            rand_mode = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
